// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the empty-queue head values, the fetch FSM encoding and the queue entry layout.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic [31:0] next_word(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Purpose: 2-entry fetch queue of {instr, pc}; head shows NOP/zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop only when non-empty; the caller never pushes into a full queue without a pop.
module fetch_queue
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push_vld,
    input  fq_entry_t  push_dat,
    input  logic       pop,
    output logic [1:0] count,
    output logic       head_vld,
    output fq_entry_t  head_dat
);

    fq_entry_t  slot0_q, slot0_d;
    fq_entry_t  slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic [1:0] count_after_pop;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        slot0_d         = slot0_q;
        slot1_d         = slot1_q;
        count_d         = count_q;
        do_pop          = pop && (count_q != 2'd0);
        do_push         = push_vld && ((count_q != 2'd2) || do_pop);
        count_after_pop = count_q - 2'(do_pop);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            // slot0 is always the head, so a pop shifts slot1 down
            if (do_pop) begin
                slot0_d = slot1_q;
            end
            if (do_push) begin
                if (count_after_pop == 2'd0) begin
                    slot0_d = push_dat;
                end else begin
                    slot1_d = push_dat;
                end
            end
            count_d = count_after_pop + 2'(do_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_vld       = (count_q != 2'd0);
        head_dat.instr = INST_NOP;
        head_dat.pc    = ZERO_WORD;
        if (head_vld) begin
            head_dat = slot0_q;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_fetch.sv
// Purpose: IF stage owning the PC; one outstanding imem request, 2-deep instruction buffer.
// Latency: request at t, 1-cycle memory responds t+1, instruction valid from t+2.
// Backpressure: stall_if holds the head; requests stop while the buffer would reach 2 entries.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic [31:0] nxpc_if
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]   q_count;
    logic         q_head_vld;
    fq_entry_t    q_head;
    fq_entry_t    q_push_dat;
    logic         pop;
    logic         push;
    logic         resp_done;
    logic         issue;
    logic [2:0]   count_next;

    assign pop        = q_head_vld && !stall_if;
    assign push       = imem_rvalid && (state_q == ST_WAIT);
    assign count_next = {1'b0, q_count} + {2'b00, push} - {2'b00, pop};
    assign resp_done  = (state_q != ST_IDLE) && imem_rvalid;

    // In WAIT fetch_pc has already moved one word past the outstanding address
    assign q_push_dat.instr = imem_rdata;
    assign q_push_dat.pc    = fetch_pc_q - 32'd4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            state_d    = (state_q != ST_IDLE && !imem_rvalid) ? ST_DROP : ST_IDLE;
        end else if ((count_next <= 3'd1) && ((state_q == ST_IDLE) || resp_done)) begin
            issue      = 1'b1;
            fetch_pc_d = next_word(fetch_pc_q);
            state_d    = ST_WAIT;
        end else if (resp_done) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_req  = rst_n && issue;
    assign imem_addr = imem_req ? fetch_pc_q : ZERO_WORD;

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_vld (push && !redirect_valid),
        .push_dat (q_push_dat),
        .pop      (pop && !redirect_valid),
        .count    (q_count),
        .head_vld (q_head_vld),
        .head_dat (q_head)
    );

    assign valid_if = q_head_vld;
    assign instr_if = q_head.instr;
    assign pc_if    = q_head.pc;
    assign nxpc_if  = q_head_vld ? next_word(q_head.pc) : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table, redirect sequences and a randomized run against a program-order model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        valid_if;
    logic [31:0] instr_if, pc_if, nxpc_if;
    logic        imem_req2, imem_rvalid2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic        valid2;
    logic [31:0] instr2, pc2, nxpc2;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_if(valid_if), .instr_if(instr_if), .pc_if(pc_if), .nxpc_if(nxpc_if)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .valid_if(valid2), .instr_if(instr2), .pc_if(pc2), .nxpc_if(nxpc2)
    );

    int          n_cmp, n_bad;
    int          cyc;
    bit          rel_pending;
    bit          pend_vld;
    int          pend_due;
    logic [31:0] pend_addr;
    int          mem_lat;
    bit          rand_lat;
    logic        req2_prev;
    logic [31:0] addr2_prev;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            32'h0000_0008: return 32'h0020_81B3;
            default:       return a ^ 32'hC3A5_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One pipeline cycle: drive inputs just after the rising edge, settle, sample on the falling edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        if (rel_pending) begin
            rst_n       = 1'b1;
            rel_pending = 1'b0;
        end
        cyc++;
        stall_if       = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_rvalid    = pend_vld && (pend_due == cyc);
        imem_rdata     = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        imem_rvalid2   = req2_prev;
        imem_rdata2    = req2_prev ? mem_word(addr2_prev) : 32'hDEAD_BEEF;
        @(negedge clk);
        if (imem_rvalid) pend_vld = 1'b0;
        if (imem_req) begin
            chk("one_outstanding", {31'b0, pend_vld}, 32'd0);
            pend_vld  = 1'b1;
            pend_due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat);
            pend_addr = imem_addr;
        end
        req2_prev  = imem_req2;
        addr2_prev = imem_addr2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        stall_if       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            imem_rvalid  = i[0];
            imem_rdata   = $urandom;
            imem_rvalid2 = i[0];
            imem_rdata2  = $urandom;
            @(negedge clk);
            chk("rst_req",   {31'b0, imem_req}, 32'd0);
            chk("rst_addr",  imem_addr, 32'h0);
            chk("rst_valid", {31'b0, valid_if}, 32'd0);
            chk("rst_instr", instr_if, 32'h0000_0013);
            chk("rst_pc",    pc_if, 32'h0);
            chk("rst_nxpc",  nxpc_if, 32'h0);
            chk("rst_req2",  {31'b0, imem_req2}, 32'd0);
            @(posedge clk);
            #1;
        end
        imem_rvalid  = 1'b0;
        imem_rvalid2 = 1'b0;
        pend_vld     = 1'b0;
        req2_prev    = 1'b0;
        cyc          = -1;
        rel_pending  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st, rd, found, prev_hold;
        logic [31:0] rpc, exp_pc, exp_instr, exp_nx, first_pc, prev_pc, prev_instr;
        int          pops, found_cyc;

        n_cmp = 0; n_bad = 0; cyc = 0; rel_pending = 1'b0;
        rst_n = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0;
        pend_vld = 1'b0; pend_due = 0; pend_addr = 32'h0; rand_lat = 1'b0; mem_lat = 1;
        req2_prev = 1'b0; addr2_prev = 32'h0;

        //              stall  req   addr           vld   pc
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0014};

        // Streaming with a 3-cycle stall, 1-cycle memory
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].stall, 1'b0, 32'h0);
            exp_instr = tbl[i].exp_vld ? mem_word(tbl[i].exp_pc) : 32'h0000_0013;
            exp_nx    = tbl[i].exp_vld ? tbl[i].exp_pc + 32'd4 : 32'h0;
            chk($sformatf("tbl%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, valid_if}, {31'b0, tbl[i].exp_vld});
            chk($sformatf("tbl%0d_pc", i),    pc_if, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), instr_if, exp_instr);
            chk($sformatf("tbl%0d_nxpc", i),  nxpc_if, exp_nx);
            if (i == 0) begin
                chk("wrap_req0",  {31'b0, imem_req2}, 32'd1);
                chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
            end else if (i == 1) begin
                chk("wrap_req1",  {31'b0, imem_req2}, 32'd1);
                chk("wrap_addr1", imem_addr2, 32'h0000_0000);
            end else if (i == 2) begin
                chk("wrap_valid", {31'b0, valid2}, 32'd1);
                chk("wrap_pc",    pc2, 32'hFFFF_FFFC);
                chk("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
                chk("wrap_nxpc",  nxpc2, 32'h0000_0000);
            end
        end

        // Redirect to 0x100 while a 3-cycle request is outstanding
        do_reset();
        mem_lat = 3;
        drive(1'b0, 1'b0, 32'h0);
        chk("rd1_req0", {31'b0, imem_req}, 32'd1);
        chk("rd1_addr0", imem_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0100);
        chk("rd1_req_on_redirect", {31'b0, imem_req}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        chk("rd1_req_drop", {31'b0, imem_req}, 32'd0);
        chk("rd1_valid_drop", {31'b0, valid_if}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        chk("rd1_req_target", {31'b0, imem_req}, 32'd1);
        chk("rd1_addr_target", imem_addr, 32'h0000_0100);
        chk("rd1_stale_not_pushed", {31'b0, valid_if}, 32'd0);
        found = 1'b0; first_pc = 32'h0; found_cyc = -1;
        for (int k = 0; k < 12 && !found; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (valid_if) begin
                found = 1'b1; first_pc = pc_if; found_cyc = cyc;
            end
        end
        chk("rd1_target_arrives", {31'b0, found}, 32'd1);
        chk("rd1_first_pc", first_pc, 32'h0000_0100);
        chk("rd1_first_cycle", found_cyc, 32'd7);

        // Redirect to 0x202 with a full queue and stall asserted
        do_reset();
        mem_lat = 1;
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        chk("rd2_full_req", {31'b0, imem_req}, 32'd0);
        chk("rd2_head_pc", pc_if, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0202);
        chk("rd2_req_on_redirect", {31'b0, imem_req}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        chk("rd2_valid_after", {31'b0, valid_if}, 32'd0);
        chk("rd2_req_after", {31'b0, imem_req}, 32'd1);
        chk("rd2_addr_after", imem_addr, 32'h0000_0200);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        chk("rd2_new_valid", {31'b0, valid_if}, 32'd1);
        chk("rd2_new_pc", pc_if, 32'h0000_0200);
        chk("rd2_new_instr", instr_if, mem_word(32'h0000_0200));

        // Randomized: popped instructions must follow program order, restarting at each redirect target
        do_reset();
        rand_lat = 1'b1;
        exp_pc = 32'h0; pops = 0; prev_hold = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : ($urandom & 32'h0000_FFFF);
            drive(st, rd, rpc);
            if (prev_hold) begin
                chk("rnd_hold_valid", {31'b0, valid_if}, 32'd1);
                chk("rnd_hold_pc", pc_if, prev_pc);
                chk("rnd_hold_instr", instr_if, prev_instr);
            end
            if (imem_req) chk("rnd_addr_align", imem_addr & 32'h3, 32'h0);
            if (rd) begin
                exp_pc = rpc & ~32'h3;
            end else if (valid_if && !st) begin
                chk("rnd_pc", pc_if, exp_pc);
                chk("rnd_instr", instr_if, mem_word(exp_pc));
                chk("rnd_nxpc", nxpc_if, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_hold  = valid_if && st && !rd;
            prev_pc    = pc_if;
            prev_instr = instr_if;
        end
        chk("rnd_progress", {31'b0, (pops > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
